pico_axi_req_arbiter: RTL

Round-robin arbiter that merges the read- or write-address request channels of C_NUM_SLAVE_PORTS user ports onto the single master address port of the memory controller. It is the request-side counterpart of the response demultiplexer. It tags each forwarded request with the originating port index in the MS bits of the master transaction ID, so responses can be routed back by those bits. It sits in the interconnect clock domain, with one instance for AR and one for AW.

---
 rtl/pico_axi_req_arbiter_if.sv | 45 ++++
 rtl/pico_axi_req_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/pico_axi_req_arbiter_if.sv
// Address-request bundle between N user ports, the round-robin arbiter and the
// memory controller's single master address port (one instance for AR, one for AW).
interface pico_axi_req_arbiter_if #(
    parameter int C_NUM_SLAVE_PORTS     = 4,
    parameter int C_AXI_SLAVE_ID_WIDTH  = 8,
    parameter int C_AXI_MASTER_ID_WIDTH = 10,
    parameter int C_AXI_ADDR_WIDTH      = 33
);
    localparam int N   = C_NUM_SLAVE_PORTS;
    localparam int SID = C_AXI_SLAVE_ID_WIDTH;
    localparam int MID = C_AXI_MASTER_ID_WIDTH;
    localparam int AW  = C_AXI_ADDR_WIDTH;

    logic [N*SID-1:0] s_axi_id;
    logic [N*AW-1:0]  s_axi_addr;
    logic [N*8-1:0]   s_axi_len;
    logic [N*3-1:0]   s_axi_size;
    logic [N*2-1:0]   s_axi_burst;
    logic [N-1:0]     s_axi_valid;
    logic [N-1:0]     s_axi_ready;

    logic [MID-1:0]   m_axi_id;
    logic [AW-1:0]    m_axi_addr;
    logic [7:0]       m_axi_len;
    logic [2:0]       m_axi_size;
    logic [1:0]       m_axi_burst;
    logic             m_axi_valid;
    logic             m_axi_ready;

    // Arbiter side: accepts user requests, presents the merged request.
    modport slave (
        input  s_axi_id, s_axi_addr, s_axi_len, s_axi_size, s_axi_burst, s_axi_valid,
        output s_axi_ready,
        output m_axi_id, m_axi_addr, m_axi_len, m_axi_size, m_axi_burst, m_axi_valid,
        input  m_axi_ready
    );

    // Environment side: user ports plus the controller's address port.
    modport master (
        output s_axi_id, s_axi_addr, s_axi_len, s_axi_size, s_axi_burst, s_axi_valid,
        input  s_axi_ready,
        input  m_axi_id, m_axi_addr, m_axi_len, m_axi_size, m_axi_burst, m_axi_valid,
        output m_axi_ready
    );
endinterface

// File: rtl/pico_axi_req_arbiter.sv
// Round-robin merge of N address-request channels onto one registered master port;
// the granted port index is carried in the top bits of the master ID for response routing.
module pico_axi_req_arbiter #(
    parameter int C_NUM_SLAVE_PORTS     = 4,
    parameter int C_AXI_SLAVE_ID_WIDTH  = 8,
    parameter int C_AXI_MASTER_ID_WIDTH = 10,
    parameter int C_AXI_ADDR_WIDTH      = 33
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pico_axi_req_arbiter_if.slave  bus
);
    localparam int N     = C_NUM_SLAVE_PORTS;
    localparam int SID   = C_AXI_SLAVE_ID_WIDTH;
    localparam int MID   = C_AXI_MASTER_ID_WIDTH;
    localparam int AW    = C_AXI_ADDR_WIDTH;
    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   cand;
    logic             grant_found;
    logic             load;

    logic             m_valid_q, m_valid_d;
    logic [MID-1:0]   m_id_q, m_id_d;
    logic [AW-1:0]    m_addr_q, m_addr_d;
    logic [7:0]       m_len_q, m_len_d;
    logic [2:0]       m_size_q, m_size_d;
    logic [1:0]       m_burst_q, m_burst_d;

    // Search starts at ptr and wraps modulo N, which need not be a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) cand = cand - (PTR_W+1)'(N);
            if (!grant_found && bus.s_axi_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    assign load = (!m_valid_q || bus.m_axi_ready) && grant_found && rst_n;

    always_comb begin
        bus.s_axi_ready = '0;
        if (load) bus.s_axi_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_id_d    = m_id_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        m_size_d  = m_size_q;
        m_burst_d = m_burst_q;
        ptr_d     = ptr_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_id_d    = {(MID-SID)'(grant_idx), bus.s_axi_id[int'(grant_idx)*SID +: SID]};
            m_addr_d  = bus.s_axi_addr[int'(grant_idx)*AW +: AW];
            m_len_d   = bus.s_axi_len[int'(grant_idx)*8 +: 8];
            m_size_d  = bus.s_axi_size[int'(grant_idx)*3 +: 3];
            m_burst_d = bus.s_axi_burst[int'(grant_idx)*2 +: 2];
            ptr_d     = (grant_idx == PTR_W'(N-1)) ? '0 : grant_idx + 1'b1;
        end else if (bus.m_axi_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_id_q    <= '0;
            m_addr_q  <= '0;
            m_len_q   <= '0;
            m_size_q  <= '0;
            m_burst_q <= '0;
            ptr_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_id_q    <= m_id_d;
            m_addr_q  <= m_addr_d;
            m_len_q   <= m_len_d;
            m_size_q  <= m_size_d;
            m_burst_q <= m_burst_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.m_axi_valid = m_valid_q;
    assign bus.m_axi_id    = m_id_q;
    assign bus.m_axi_addr  = m_addr_q;
    assign bus.m_axi_len   = m_len_q;
    assign bus.m_axi_size  = m_size_q;
    assign bus.m_axi_burst = m_burst_q;
endmodule
